// File: rtl/dtv2_macc_pipe_if.sv
// Handshake bundle between the activation/weight buffers, the BF16 MAC pipe
// and the output stage. The slave modport is the pipe's own view.
interface dtv2_macc_pipe_if #(
  parameter int NUM_PE = 16,
  parameter int DW     = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 in_mode;
  logic                       in_first;
  logic                       in_last;
  logic [NUM_PE-1:0][DW-1:0]  din_act;
  logic [NUM_PE-1:0][DW-1:0]  din_weight;
  logic                       out_valid;
  logic                       out_ready;
  logic [1:0]                 out_mode;
  logic [NUM_PE-1:0][DW-1:0]  dout;

  modport master (
    output in_valid, in_mode, in_first, in_last, din_act, din_weight, out_ready,
    input  in_ready, out_valid, out_mode, dout
  );

  modport slave (
    input  in_valid, in_mode, in_first, in_last, din_act, din_weight, out_ready,
    output in_ready, out_valid, out_mode, dout
  );
endinterface

// File: rtl/dtv2_macc_pipe.sv
// BF16 multiply / adder-tree / accumulate pipeline with EWMUL, LANE_MAC and DOT
// modes, fixed latency and global back-pressure.
module dtv2_macc_pipe #(
  parameter int NUM_PE     = 16,
  parameter int SIG_WIDTH  = 7,
  parameter int EXP_WIDTH  = 8,
  parameter int IEEE_COMPL = 1,
  parameter int DW         = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic              clk,
  input  logic              rstn,
  dtv2_macc_pipe_if.slave   bus,
  input  logic              status_clr,
  output logic [2:0]        status_sticky
);

  localparam int TREE_LVLS = $clog2(NUM_PE);
  localparam int LAT       = TREE_LVLS + 2;
  localparam int T         = LAT - 2;
  localparam int M         = SIG_WIDTH;
  localparam int E         = EXP_WIDTH;
  localparam int BIAS      = (1 << (E - 1)) - 1;
  localparam int EMAX_I    = (1 << E) - 1;

  localparam logic [1:0] MODE_EW  = 2'd0;
  localparam logic [1:0] MODE_MAC = 2'd1;
  localparam logic [1:0] MODE_DOT = 2'd2;

  localparam logic [DW-1:0] INF_P = {1'b0, {E{1'b1}}, {M{1'b0}}};
  localparam logic [DW-1:0] QNAN  = (IEEE_COMPL != 0) ?
                                    {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}} : INF_P;

  typedef logic [NUM_PE-1:0][DW-1:0] lanes_t;
  // {invalid, huge, inf, value}
  typedef logic [DW+2:0] fpres_t;

  // Round-to-nearest-even, saturate to Inf on overflow, flush tiny results to zero.
  function automatic fpres_t fp_round(input logic s, input int e, input logic [M:0] n,
                                      input logic g, input logic st);
    logic [M+1:0] r;
    int           ee;
    r  = {1'b0, n} + {{(M+1){1'b0}}, g & (st | n[0])};
    ee = e;
    if (r[M+1]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= EMAX_I) return {3'b011, s, {E{1'b1}}, {M{1'b0}}};
    if (ee <= 0)      return {3'b000, s, {(DW-1){1'b0}}};
    return {3'b000, s, ee[E-1:0], r[M-1:0]};
  endfunction

  function automatic fpres_t fp_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [E-1:0]     ea, eb;
    logic [M-1:0]     fa, fb;
    logic             s, za, zb, ia, ib, na, nb;
    logic [2*M+1:0]   p;
    int               e;
    ea = a[DW-2:M]; fa = a[M-1:0];
    eb = b[DW-2:M]; fb = b[M-1:0];
    s  = a[DW-1] ^ b[DW-1];
    za = (ea == '0); ia = (ea == '1) && (fa == '0); na = (ea == '1) && (fa != '0);
    zb = (eb == '0); ib = (eb == '1) && (fb == '0); nb = (eb == '1) && (fb != '0);
    if (na || nb)                 return {3'b000, QNAN};
    if ((ia && zb) || (ib && za)) return {3'b100, QNAN};
    if (ia || ib)                 return {3'b001, s, INF_P[DW-2:0]};
    if (za || zb)                 return {3'b000, s, {(DW-1){1'b0}}};
    p = {{(M+1){1'b0}}, 1'b1, fa} * {{(M+1){1'b0}}, 1'b1, fb};
    e = int'(ea) + int'(eb) - BIAS;
    if (p[2*M+1]) e = e + 1;
    else          p = p << 1;
    return fp_round(s, e, p[2*M+1:M+1], p[M], |p[M-1:0]);
  endfunction

  function automatic fpres_t fp_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [E-1:0]   ea, eb;
    logic [M-1:0]   fa, fb;
    logic           za, zb, ia, ib, na, nb, st, found;
    logic [DW-1:0]  x, y;
    logic [M+3:0]   mx, my, ms, n;
    logic [M+4:0]   sum;
    int             d, e, lz;
    ea = a[DW-2:M]; fa = a[M-1:0];
    eb = b[DW-2:M]; fb = b[M-1:0];
    za = (ea == '0); ia = (ea == '1) && (fa == '0); na = (ea == '1) && (fa != '0);
    zb = (eb == '0); ib = (eb == '1) && (fb == '0); nb = (eb == '1) && (fb != '0);
    if (na || nb)                        return {3'b000, QNAN};
    if (ia && ib && (a[DW-1] != b[DW-1])) return {3'b100, QNAN};
    if (ia)                              return {3'b001, a};
    if (ib)                              return {3'b001, b};
    if (za && zb)                        return {3'b000, a[DW-1] & b[DW-1], {(DW-1){1'b0}}};
    if (za)                              return {3'b000, b};
    if (zb)                              return {3'b000, a};
    if (a[DW-2:0] >= b[DW-2:0]) begin x = a; y = b; end
    else                        begin x = b; y = a; end
    d  = int'(x[DW-2:M]) - int'(y[DW-2:M]);
    e  = int'(x[DW-2:M]);
    mx = {1'b1, x[M-1:0], 3'b000};
    my = {1'b1, y[M-1:0], 3'b000};
    st = 1'b0;
    for (int i = 0; i < M + 4; i++) if (i < d && my[i]) st = 1'b1;
    ms    = my >> d;
    ms[0] = ms[0] | st;
    if (x[DW-1] == y[DW-1]) begin
      sum = {1'b0, mx} + {1'b0, ms};
      if (sum[M+4]) begin
        n    = sum[M+4:1];
        n[0] = n[0] | sum[0];
        e    = e + 1;
      end else begin
        n = sum[M+3:0];
      end
    end else begin
      n = mx - ms;
      if (n == '0) return '0;
      lz    = 0;
      found = 1'b0;
      for (int i = M + 3; i >= 0; i--) begin
        if (!found) begin
          if (n[i]) found = 1'b1;
          else      lz = lz + 1;
        end
      end
      n = n << lz;
      e = e - lz;
    end
    return fp_round(x[DW-1], e, n[M+3:3], n[2], |n[1:0]);
  endfunction

  logic        adv;
  lanes_t      act_p0_q, act_p0_d, wgt_p0_q, wgt_p0_d;
  logic        vld_p0_q, vld_p0_d, first_p0_q, first_p0_d, last_p0_q, last_p0_d;
  logic [1:0]  mode_p0_q, mode_p0_d;
  lanes_t      lane_q [0:T];
  lanes_t      lane_d [0:T];
  logic [1:0]  mode_q [0:T];
  logic [1:0]  mode_d [0:T];
  logic [T:0]  vld_q, vld_d, first_q, first_d, last_q, last_d;
  lanes_t      acc_q, acc_d, dout_q, dout_d, acc_sum;
  logic        out_valid_q, out_valid_d;
  logic [1:0]  out_mode_q, out_mode_d;
  logic [2:0]  sticky_q, sticky_d, st_set;
  fpres_t      mul_r, tree_r, acc_r;

  always_comb begin
    adv    = !(out_valid_q && !bus.out_ready);
    st_set = '0;
    mul_r  = '0;
    tree_r = '0;
    acc_r  = '0;

    // p0: operand capture
    act_p0_d   = act_p0_q;
    wgt_p0_d   = wgt_p0_q;
    vld_p0_d   = vld_p0_q;
    mode_p0_d  = mode_p0_q;
    first_p0_d = first_p0_q;
    last_p0_d  = last_p0_q;
    if (adv) begin
      act_p0_d   = bus.din_act;
      wgt_p0_d   = bus.din_weight;
      vld_p0_d   = bus.in_valid;
      mode_p0_d  = (bus.in_mode == 2'd3) ? MODE_EW : bus.in_mode;
      first_p0_d = bus.in_first;
      last_p0_d  = bus.in_last;
    end

    lane_d  = lane_q;
    mode_d  = mode_q;
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    if (adv) begin
      // p1: lane products
      vld_d[0]   = vld_p0_q;
      mode_d[0]  = mode_p0_q;
      first_d[0] = first_p0_q;
      last_d[0]  = last_p0_q;
      for (int i = 0; i < NUM_PE; i++) begin
        mul_r        = fp_mul(act_p0_q[i], wgt_p0_q[i]);
        lane_d[0][i] = mul_r[DW-1:0];
        if (vld_p0_q) st_set = st_set | mul_r[DW+2:DW];
      end
      // tree levels: pairwise sums in DOT, plain delay otherwise
      for (int k = 1; k <= T; k++) begin
        vld_d[k]   = vld_q[k-1];
        mode_d[k]  = mode_q[k-1];
        first_d[k] = first_q[k-1];
        last_d[k]  = last_q[k-1];
        lane_d[k]  = lane_q[k-1];
        if (mode_q[k-1] == MODE_DOT) begin
          lane_d[k] = '0;
          for (int i = 0; i < NUM_PE / 2; i++) begin
            if (i < (NUM_PE >> k)) begin
              tree_r       = fp_add(lane_q[k-1][2*i], lane_q[k-1][2*i+1]);
              lane_d[k][i] = tree_r[DW-1:0];
              if (vld_q[k-1]) st_set = st_set | tree_r[DW+2:DW];
            end
          end
        end
      end
    end

    // final stage: accumulate and register the result
    for (int i = 0; i < NUM_PE; i++) begin
      acc_r      = fp_add(lane_q[T][i], first_q[T] ? '0 : acc_q[i]);
      acc_sum[i] = acc_r[DW-1:0];
      if (adv && vld_q[T] &&
          ((mode_q[T] == MODE_MAC) || ((mode_q[T] == MODE_DOT) && (i == 0))))
        st_set = st_set | acc_r[DW+2:DW];
    end

    acc_d       = acc_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    out_mode_d  = out_mode_q;
    if (adv) begin
      out_valid_d = 1'b0;
      if (vld_q[T]) begin
        case (mode_q[T])
          MODE_MAC: begin
            acc_d = acc_sum;
            if (last_q[T]) begin
              out_valid_d = 1'b1;
              dout_d      = acc_sum;
              out_mode_d  = MODE_MAC;
            end
          end
          MODE_DOT: begin
            acc_d[0] = acc_sum[0];
            if (last_q[T]) begin
              out_valid_d = 1'b1;
              dout_d      = '0;
              dout_d[0]   = acc_sum[0];
              out_mode_d  = MODE_DOT;
            end
          end
          default: begin
            out_valid_d = 1'b1;
            dout_d      = lane_q[T];
            out_mode_d  = mode_q[T];
          end
        endcase
      end
    end

    sticky_d = status_clr ? 3'b000 : (sticky_q | st_set);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p0_q    <= 1'b0;
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 2'd0;
      dout_q      <= '0;
      acc_q       <= '0;
      sticky_q    <= 3'b000;
    end else begin
      vld_p0_q    <= vld_p0_d;
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      dout_q      <= dout_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    act_p0_q   <= act_p0_d;
    wgt_p0_q   <= wgt_p0_d;
    mode_p0_q  <= mode_p0_d;
    first_p0_q <= first_p0_d;
    last_p0_q  <= last_p0_d;
    lane_q     <= lane_d;
    mode_q     <= mode_d;
    first_q    <= first_d;
    last_q     <= last_d;
  end

  assign bus.in_ready   = adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_mode   = out_mode_q;
  assign bus.dout       = dout_q;
  assign status_sticky  = sticky_q;

endmodule

// File: tb/tb_dtv2_macc_pipe.sv
// Directed bench for dtv2_macc_pipe with NUM_PE=4 and hand-computed BF16 results.
module tb_dtv2_macc_pipe;
  localparam int NPE = 4;
  localparam int DW  = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       status_clr = 1'b0;
  logic [2:0] status_sticky;
  int         checks = 0;
  int         errors = 0;

  logic [15:0] stall_w [8] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0,
                               16'h40C0, 16'h40E0, 16'h4100, 16'h4110};

  always #5 clk = ~clk;

  dtv2_macc_pipe_if #(.NUM_PE(NPE), .DW(DW)) bus ();

  dtv2_macc_pipe #(
    .NUM_PE(NPE), .SIG_WIDTH(7), .EXP_WIDTH(8), .IEEE_COMPL(1), .DW(DW)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .status_clr(status_clr), .status_sticky(status_sticky)
  );

  // act lanes {-1, 0.5, 2, 1} times a positive weight w
  function automatic logic [63:0] exp_ew(input logic [15:0] w);
    return {w | 16'h8000, w - 16'h0080, w + 16'h0080, w};
  endfunction

  task automatic drive(input logic [1:0] m, input logic f, input logic l,
                       input logic [63:0] a, input logic [63:0] w);
    bus.in_valid   = 1'b1;
    bus.in_mode    = m;
    bus.in_first   = f;
    bus.in_last    = l;
    bus.din_act    = a;
    bus.din_weight = w;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic await_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.dout !== 64'h0 || bus.out_mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b dout=%h mode=%0d want 0/0/0",
               bus.out_valid, bus.dout, bus.out_mode);
    end
    checks++;
    if (status_sticky !== 3'b000) begin
      errors++; $display("FAIL reset_sticky got %b want 000", status_sticky);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_ewmul;
    int lat;
    drive(2'd0, 1'b0, 1'b0, {16'h3F00, 16'h4040, 16'h4000, 16'h3F80}, {4{16'h4000}});
    await_out(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL ewmul_latency got %0d want 4", lat); end
    checks++;
    if (bus.dout !== {16'h3F80, 16'h40C0, 16'h4080, 16'h4000} || bus.out_mode !== 2'd0) begin
      errors++;
      $display("FAIL ewmul_dout got %h mode %0d want 3f8040c040804000 mode 0", bus.dout, bus.out_mode);
    end
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ewmul_single got %b want 0", bus.out_valid); end
    // mode 3 behaves as element-wise multiply
    drive(2'd3, 1'b0, 1'b0, {16'h3F00, 16'h4040, 16'h4000, 16'h3F80}, {4{16'h4040}});
    await_out(lat);
    checks++;
    if (lat != 4 || bus.dout !== {16'h3FC0, 16'h4110, 16'h40C0, 16'h4040}) begin
      errors++;
      $display("FAIL mode3_ewmul got lat %0d dout %h want 4 3fc0411040c04040", lat, bus.dout);
    end
    idle(2);
  endtask

  task automatic test_dot;
    int lat;
    drive(2'd2, 1'b1, 1'b1, {4{16'h3F80}}, {4{16'h4000}});
    await_out(lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL dot_latency got %0d want 4", lat); end
    checks++;
    if (bus.dout !== {48'h0, 16'h4100} || bus.out_mode !== 2'd2) begin
      errors++; $display("FAIL dot_single got %h mode %0d want 4100 mode 2", bus.dout, bus.out_mode);
    end
    idle(1);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dot_once got %b want 0", bus.out_valid); end
    // 8 + 16 = 24
    drive(2'd2, 1'b1, 1'b0, {4{16'h3F80}}, {4{16'h4000}});
    drive(2'd2, 1'b0, 1'b1, {4{16'h4000}}, {4{16'h4000}});
    await_out(lat);
    checks++;
    if (lat != 4 || bus.dout !== {48'h0, 16'h41C0}) begin
      errors++; $display("FAIL dot_accum got lat %0d dout %h want 4 41c0", lat, bus.dout);
    end
    idle(2);
  endtask

  task automatic test_lane_mac;
    int          pulses, at_k;
    logic        hold_bad;
    logic [63:0] got;
    logic [1:0]  got_mode;
    logic [63:0] prev;
    prev = bus.dout;
    pulses = 0; at_k = -1; hold_bad = 1'b0; got = '0; got_mode = '0;
    drive(2'd1, 1'b1, 1'b0, {4{16'h3F80}}, {4{16'h3F80}});
    drive(2'd1, 1'b0, 1'b0, {4{16'h3F80}}, {4{16'h3F80}});
    drive(2'd1, 1'b0, 1'b1, {4{16'h3F80}}, {4{16'h3F80}});
    for (int k = 0; k <= 8; k++) begin
      if (bus.out_valid) begin
        pulses++; at_k = k; got = bus.dout; got_mode = bus.out_mode;
      end else if (at_k < 0 && bus.dout !== prev) begin
        hold_bad = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1 || at_k != 4) begin
      errors++; $display("FAIL mac_emit got pulses %0d at %0d want 1 at 4", pulses, at_k);
    end
    checks++;
    if (got !== {4{16'h4040}} || got_mode !== 2'd1) begin
      errors++; $display("FAIL mac_dout got %h mode %0d want 4040x4 mode 1", got, got_mode);
    end
    checks++;
    if (hold_bad) begin errors++; $display("FAIL mac_dout_hold got changed want %h", prev); end
  endtask

  task automatic test_stall;
    int          tx, rx, stall_bad, order_bad, extra;
    logic [63:0] prev_d;
    tx = 0; rx = 0; stall_bad = 0; order_bad = 0; extra = 0; prev_d = '0;
    for (int c = 0; c < 60 && rx < 8; c++) begin
      bus.out_ready = !(c >= 5 && c < 10);
      bus.in_valid  = (tx < 8);
      bus.in_mode   = 2'd0;
      bus.din_act   = {16'hBF80, 16'h3F00, 16'h4000, 16'h3F80};
      if (tx < 8) bus.din_weight = {4{stall_w[tx]}};
      #4;
      if (!bus.out_ready) begin
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || (c > 5 && bus.dout !== prev_d))
          stall_bad++;
      end
      prev_d = bus.dout;
      if (bus.in_valid && bus.in_ready) tx++;
      if (bus.out_valid && bus.out_ready) begin
        if (rx < 8 && bus.dout !== exp_ew(stall_w[rx])) order_bad++;
        rx++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_bad); end
    checks++;
    if (tx != 8 || rx != 8 || extra != 0) begin
      errors++; $display("FAIL stall_count got tx %0d rx %0d extra %0d want 8 8 0", tx, rx, extra);
    end
    checks++;
    if (order_bad != 0) begin errors++; $display("FAIL stall_order got %0d wrong beats want 0", order_bad); end
  endtask

  task automatic test_status;
    int lat;
    status_clr = 1'b1; idle(1); status_clr = 1'b0;
    checks++;
    if (status_sticky !== 3'b000) begin errors++; $display("FAIL status_clear0 got %b want 000", status_sticky); end
    drive(2'd0, 1'b0, 1'b0, {16'h3F80, 16'h3F80, 16'h3F80, 16'h7F7F}, {4{16'h4000}});
    await_out(lat);
    checks++;
    if (lat != 4 || bus.dout !== {16'h4000, 16'h4000, 16'h4000, 16'h7F80}) begin
      errors++; $display("FAIL overflow_dout got lat %0d dout %h want 4 4000400040007f80", lat, bus.dout);
    end
    checks++;
    if (status_sticky !== 3'b011) begin errors++; $display("FAIL overflow_sticky got %b want 011", status_sticky); end
    idle(1);
    status_clr = 1'b1; idle(1); status_clr = 1'b0;
    checks++;
    if (status_sticky !== 3'b000) begin errors++; $display("FAIL status_clear got %b want 000", status_sticky); end
    // clear coincides with the multiplier status update
    drive(2'd0, 1'b0, 1'b0, {16'h3F80, 16'h3F80, 16'h3F80, 16'h7F7F}, {4{16'h4000}});
    status_clr = 1'b1; idle(1); status_clr = 1'b0;
    await_out(lat);
    checks++;
    if (status_sticky !== 3'b000) begin errors++; $display("FAIL clr_wins got %b want 000", status_sticky); end
    idle(1);
    drive(2'd0, 1'b0, 1'b0, {16'h3F80, 16'h3F80, 16'h3F80, 16'h0000},
          {16'h4000, 16'h4000, 16'h4000, 16'h7F80});
    await_out(lat);
    checks++;
    if (bus.dout !== {16'h4000, 16'h4000, 16'h4000, 16'h7FC0} || status_sticky !== 3'b100) begin
      errors++;
      $display("FAIL invalid_op got dout %h sticky %b want 4000400040007fc0 100", bus.dout, status_sticky);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_dot;
    int lat, seen;
    seen = 0;
    drive(2'd2, 1'b1, 1'b0, {4{16'h3F80}}, {4{16'h4000}});
    drive(2'd2, 1'b0, 1'b0, {4{16'h3F80}}, {4{16'h4000}});
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    checks++;
    if (status_sticky !== 3'b000) begin errors++; $display("FAIL rst_sticky got %b want 000", status_sticky); end
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_inflight got %0d outputs want 0", seen); end
    // no first after reset: accumulator starts from +0
    drive(2'd2, 1'b0, 1'b1, {4{16'h4000}}, {4{16'h4000}});
    await_out(lat);
    checks++;
    if (lat != 4 || bus.dout !== {48'h0, 16'h4180}) begin
      errors++; $display("FAIL rst_acc_zero got lat %0d dout %h want 4 4180", lat, bus.dout);
    end
    idle(1);
    drive(2'd2, 1'b1, 1'b1, {4{16'h3F80}}, {4{16'h4000}});
    await_out(lat);
    checks++;
    if (lat != 4 || bus.dout !== {48'h0, 16'h4100} || status_sticky !== 3'b000) begin
      errors++;
      $display("FAIL rst_new_dot got lat %0d dout %h sticky %b want 4 4100 000", lat, bus.dout, status_sticky);
    end
    idle(2);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_mode    = 2'd0;
    bus.in_first   = 1'b0;
    bus.in_last    = 1'b0;
    bus.din_act    = '0;
    bus.din_weight = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_ewmul();
    test_dot();
    test_lane_mac();
    test_stall();
    test_status();
    test_reset_mid_dot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
